reg_writeback: RTL
==================

Name: reg_writeback

Overview:
- Write-back stage for the single-cycle MIPS ALU datapath. It is the write side of the register file, whose read side sits downstream of the instruction register.
- Aligns the destination register and function code latched by the instruction register with the ALU result one clock later, and drives RegWrite/WriteReg/WriteData into the register file write port.
- Also supplies forwarding hints for the read ports and a retire counter with optional halt.

Parameters:
- WARMUP, 2, clock edges after reset release before IssueValid is honoured (covers PC / instruction-memory fill).
- MAX_RETIRE, 0, number of committed writes after which the block halts; 0 = never halt.
- CNT_W, 16, width of RetireCount.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- IssueValid  in  1  instruction-register contents (WriteReg, FuncCode) are a new instruction this cycle.
- WriteReg  in  5  rd field from the instruction register.
- FuncCode  in  6  funct field from the instruction register.
- ALUOut  in  32  ALU result; valid the cycle after the matching IssueValid.
- Stall  in  1  freeze pipeline; no commit while high.
- ReadReg1  in  5  rs being read, for the forwarding compare.
- ReadReg2  in  5  rt being read, for the forwarding compare.
- RegWrite  out  1  register file write enable, one-cycle pulse per commit.
- WB_Reg  out  5  register file write address.
- WriteData  out  32  register file write data.
- FwdA  out  1  ReadReg1 matches the write in flight.
- FwdB  out  1  ReadReg2 matches the write in flight.
- Illegal  out  1  one-cycle pulse: an unsupported funct reached commit.
- RetireCount  out  CNT_W  number of committed writes.
- Halted  out  1  retire limit reached.

Behaviour:
- Reset (RESET=0, asynchronous):
  - RegWrite=0, WB_Reg=0, WriteData=0, Illegal=0, RetireCount=0, Halted=0.
  - s1_valid=0, warm-up counter=0, state=WARM.
- FSM states: WARM, RUN, HALT.
  - WARM: counts posedges after RESET rises; IssueValid is ignored. Moves to RUN on the edge where the count reaches WARMUP. WARMUP=0 means RUN on the first edge.
  - RUN: normal operation. Moves to HALT on the edge where a commit makes RetireCount equal MAX_RETIRE (only when MAX_RETIRE≠0).
  - HALT: Halted=1. No further commits. s1 loads are ignored. Only reset exits HALT.
- Stage 1 (posedge t, RUN, Stall=0): s1_valid<=IssueValid, s1_reg<=WriteReg, s1_funct<=FuncCode.
- Commit (posedge t+1, RUN, Stall=0, s1_valid=1):
  - legal = s1_funct in {32,34,36,37,39,42}.
  - RegWrite <= legal && s1_reg≠0.
  - WB_Reg <= s1_reg; WriteData <= ALUOut sampled at this edge.
  - Illegal <= !legal.
  - RetireCount increments iff RegWrite is set.
- Latency: IssueValid sampled at edge t gives a RegWrite pulse during the cycle after edge t+1. Back-to-back issues give back-to-back pulses (throughput 1/cycle).
- Destination r0: never written. No RegWrite, no count increment, Illegal=0.
- RegWrite and Illegal are single-cycle. They are cleared on any edge without a commit.
- Stall=1 at an edge: s1 holds its contents, RegWrite<=0, Illegal<=0, counters hold. A held s1 entry commits at the first edge with Stall=0, using ALUOut at that edge.
- Forwarding (combinational from registered outputs):
  - FwdA = RegWrite && WB_Reg≠0 && WB_Reg==ReadReg1.
  - FwdB is the same with ReadReg2.
- RetireCount wraps modulo 2^CNT_W when MAX_RETIRE=0.
- Reset mid-operation: all state clears immediately. The in-flight s1 entry is discarded and no write is issued.

Test Plan:
- Reset release with WARMUP=2, IssueValid=1 held from the start → no RegWrite before edge 4; first write pulse after edge 4.
- Issue rd=2, funct=32, ALUOut=0x0000_0005 next cycle → single pulse RegWrite=1, WB_Reg=2, WriteData=5; RetireCount=1.
- Back-to-back issues rd=5 funct=36 then rd=8 funct=37 (ALUOut 0xF0, 0x0F) → consecutive pulses (5,0xF0), (8,0x0F); FwdA=1 while ReadReg1=8 during the second pulse.
- Issue rd=0 funct=32, then rd=9 funct=50 → no RegWrite for either; Illegal pulses once for funct 50; RetireCount unchanged.
- Issue rd=11 funct=34, Stall=1 for 3 cycles, then ALUOut=0x1234 → write of 0x1234 to r11 exactly once, after Stall falls.
- MAX_RETIRE=2, issue 3 legal writes → two pulses, Halted=1, third dropped. Drive RESET=0 mid-pulse → RegWrite and RetireCount drop to 0 without waiting for a clock.

Source files
------------

// File: rtl/reg_writeback.sv
// Write-back stage: lines the latched rd/funct up with the ALU result one clock
// later and drives the register file write port, forwarding hints and a retire counter.
module reg_writeback #(
    parameter int WARMUP     = 2,
    parameter int MAX_RETIRE = 0,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IssueValid,
    input  logic [4:0]       WriteReg,
    input  logic [5:0]       FuncCode,
    input  logic [31:0]      ALUOut,
    input  logic             Stall,
    input  logic [4:0]       ReadReg1,
    input  logic [4:0]       ReadReg2,
    output logic             RegWrite,
    output logic [4:0]       WB_Reg,
    output logic [31:0]      WriteData,
    output logic             FwdA,
    output logic             FwdB,
    output logic             Illegal,
    output logic [CNT_W-1:0] RetireCount,
    output logic             Halted
);

    localparam int WC_W    = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam int N_LEGAL = 6;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETIRE);
    // add, sub, and, or, nor, slt
    localparam logic [6*N_LEGAL-1:0] LEGAL_LIST =
        {6'd42, 6'd39, 6'd37, 6'd36, 6'd34, 6'd32};

    typedef enum logic [1:0] {WARM, RUN, HALT} state_t;

    state_t            state_reg, state_next;
    logic [WC_W-1:0]   warm_cnt_reg, warm_cnt_next;
    logic [31:0]       warm_inc;

    logic              s1_valid_reg, s1_valid_next;
    logic [4:0]        s1_rd_reg, s1_rd_next;
    logic [5:0]        s1_funct_reg, s1_funct_next;

    logic              reg_write_reg, reg_write_next;
    logic [4:0]        wb_reg_reg, wb_reg_next;
    logic [31:0]       write_data_reg, write_data_next;
    logic              illegal_reg, illegal_next;
    logic [CNT_W-1:0]  retire_cnt_reg, retire_cnt_next;
    logic [CNT_W-1:0]  retire_inc;

    logic [N_LEGAL-1:0] legal_hit;
    logic               legal;
    logic               advance;
    logic               commit;
    logic               do_write;
    logic               halt_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_LEGAL; gi++) begin : g_legal
            assign legal_hit[gi] = (s1_funct_reg == LEGAL_LIST[gi*6 +: 6]);
        end
    endgenerate

    assign legal      = |legal_hit;
    assign advance    = (state_reg == RUN) && !Stall;
    assign commit     = advance && s1_valid_reg;
    assign do_write   = commit && legal && (s1_rd_reg != 5'd0);
    assign retire_inc = retire_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    assign halt_hit   = (MAX_RETIRE != 0) && do_write && (retire_inc == MAX_CNT);
    assign warm_inc   = 32'(warm_cnt_reg) + 32'd1;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        case (state_reg)
            WARM: begin
                warm_cnt_next = WC_W'(warm_inc);
                if (warm_inc >= 32'(WARMUP)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_hit) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = WARM;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= WARM;
            warm_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 latch and commit
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_next   = s1_valid_reg;
        s1_rd_next      = s1_rd_reg;
        s1_funct_next   = s1_funct_reg;
        reg_write_next  = 1'b0;
        illegal_next    = 1'b0;
        wb_reg_next     = wb_reg_reg;
        write_data_next = write_data_reg;
        retire_cnt_next = retire_cnt_reg;

        // Stall or a non-RUN state leaves s1 untouched so a held entry survives
        if (advance) begin
            s1_valid_next = IssueValid;
            s1_rd_next    = WriteReg;
            s1_funct_next = FuncCode;
        end

        if (commit) begin
            reg_write_next  = do_write;
            wb_reg_next     = s1_rd_reg;
            write_data_next = ALUOut;
            illegal_next    = !legal;
            if (do_write) begin
                retire_cnt_next = retire_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_valid_reg   <= 1'b0;
            s1_rd_reg      <= 5'd0;
            s1_funct_reg   <= 6'd0;
            reg_write_reg  <= 1'b0;
            wb_reg_reg     <= 5'd0;
            write_data_reg <= 32'd0;
            illegal_reg    <= 1'b0;
            retire_cnt_reg <= '0;
        end else begin
            s1_valid_reg   <= s1_valid_next;
            s1_rd_reg      <= s1_rd_next;
            s1_funct_reg   <= s1_funct_next;
            reg_write_reg  <= reg_write_next;
            wb_reg_reg     <= wb_reg_next;
            write_data_reg <= write_data_next;
            illegal_reg    <= illegal_next;
            retire_cnt_reg <= retire_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RegWrite    = reg_write_reg;
    assign WB_Reg      = wb_reg_reg;
    assign WriteData   = write_data_reg;
    assign Illegal     = illegal_reg;
    assign RetireCount = retire_cnt_reg;
    assign Halted      = (state_reg == HALT);

    assign FwdA = reg_write_reg && (wb_reg_reg != 5'd0) && (wb_reg_reg == ReadReg1);
    assign FwdB = reg_write_reg && (wb_reg_reg != 5'd0) && (wb_reg_reg == ReadReg2);

endmodule
